angles_hit_scanner: RTL and testbench
=====================================

// Module: angles_hit_scanner
// PURPOSE
//  Consumer end of the 16-sector hit-mask interface. Latches a one-hot-per-sector
//  angles_hit mask on start and serialises it into a stream of 4-bit sector indices
//  over a valid/ready handshake, lowest index first.
//  Feeds the per-sector enemy-kill logic, which resolves one sector per handshake.
// PARAMETERS
//  NUM_ANGLES  16  number of angular sectors; equals the angles_hit width
//  ANGLE_W     4   sector index width; NUM_ANGLES == 2**ANGLE_W
// PORTS
//  clk          in   1         system clock; all state is updated on its rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  start        in   1         request a scan of angles_hit; sampled only in IDLE
//  angles_hit   in   16        sector hit mask; bit i set = sector i hit
//  busy         out  1         high in SCAN and DONE
//  angle_valid  out  1         angle_out holds a pending hit sector
//  angle_ready  in   1         consumer accepts angle_out this cycle
//  angle_out    out  4         index of the lowest pending set bit
//  done         out  1         one-cycle pulse; the scan has finished
//  hit_count    out  5         only when ANGLES_HIT_COUNT_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, busy=0, angle_valid=0, angle_out=0, done=0, hit_count=0.
//  The reset is asynchronous and takes effect immediately, including mid-scan.
//  Outstanding sectors are dropped, and no done pulse is issued for the aborted scan.
//  IDLE:
//   - start=1 latches pending<=angles_hit.
//   - If angles_hit!=0, go to SCAN. Otherwise go to DONE.
//  SCAN:
//   - angle_valid=1. angle_out = priority encode of the lowest set bit of the registered pending.
//   - On angle_valid & angle_ready, clear that bit.
//   - If the cleared pending==0, go to DONE. Otherwise stay in SCAN; the next index is
//     presented the following cycle.
//   - With angle_ready=0, angle_out and angle_valid hold stable and pending is unchanged.
//  DONE:
//   - done=1 and angle_valid=0 for exactly one cycle, then return to IDLE unconditionally.
//  Latency:
//   - start at cycle N gives the first angle_valid at N+1.
//   - With angle_ready held high, k set bits produce k consecutive valid cycles, and done
//     follows on the next cycle.
//   - A zero mask gives done at N+1.
//  Ordering: sectors are issued in strictly ascending index, with no wrap-around reordering.
//   - Example: a mask straddling 15->0 issues 0,1,... before 14,15.
//  start while busy is ignored. The angles_hit mask is sampled only on the start cycle.
//  A changing angles_hit during a scan has no effect.
//  Back-to-back scans: start is accepted in the IDLE cycle immediately following DONE.
//  angle_out is don't-care when angle_valid=0, but is driven to 0 outside SCAN.
// CONFIGURATION
//  ANGLES_HIT_COUNT_EN defined:
//   - hit_count = popcount of the mask, registered on the start cycle (range 0..16).
//   - It holds that value until the next accepted start or reset.
//  ANGLES_HIT_COUNT_EN undefined: the hit_count port and the popcount logic are absent.
// STRUCTURE
//  Shared package angles_pkg:
//   - NUM_ANGLES and ANGLE_W constants.
//   - Scanner state encoding: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
//  Sub-module lsb_priority_encoder (NUM_ANGLES-in):
//   - Combinational lowest-set-bit index plus an any-set flag.
//   - Instantiated once, on the pending register.
//  Top level: FSM, pending register with bit clear, optional popcount.
// TESTING
//  1 start, mask=16'h000E, ready=1 -> angle_out 1,2,3 at N+1..N+3; done at N+4; hit_count=3
//  2 start, mask=16'hC007, ready=1 -> angle_out 0,1,2,14,15 on 5 consecutive cycles; then done
//  3 start, mask=16'h0000 -> no angle_valid; done=1 at N+1 only; busy=1 for one cycle
//  4 mask=16'h0120, ready=0 for 3 cycles -> angle_out holds 5 with valid=1; ready=1 -> 8 next
//  5 start pulsed during SCAN with a different mask -> ignored; original sequence completes
//  6 rst_n low mid-scan (mask=16'hFFFF after 4 handshakes) -> all outputs 0 immediately
//    -> state IDLE; no done pulse

Source files
------------

// File: rtl/angles_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : angles_pkg                                                   |
// | Description : Sector geometry, scanner state encoding and a popcount helper|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package angles_pkg;

  localparam int NUM_ANGLES = 16;
  localparam int ANGLE_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  function automatic logic [ANGLE_W:0] popcount(input logic [NUM_ANGLES-1:0] v);
    logic [ANGLE_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_ANGLES; i++) begin
      n = n + {{ANGLE_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/angles_hit_scanner_lsb_priority_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsb_priority_encoder                                         |
// | Description : Index of the lowest set request bit plus an any-set flag     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsb_priority_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

  assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/angles_hit_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : angles_hit_scanner                                           |
// | Description : Latches a 16-sector hit mask and streams set sector indices, |
// |               lowest first, over valid/ready. Optional hit_count port is   |
// |               enabled by defining ANGLES_HIT_COUNT_EN.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module angles_hit_scanner
  import angles_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_ANGLES-1:0] angles_hit,
  output logic                  busy,
  output logic                  angle_valid,
  input  logic                  angle_ready,
  output logic [ANGLE_W-1:0]    angle_out,
  output logic                  done
`ifdef ANGLES_HIT_COUNT_EN
  ,
  output logic [ANGLE_W:0]      hit_count
`endif
);

  scan_state_t           r_state;
  logic [NUM_ANGLES-1:0] r_pending;
  logic                  r_busy;
  logic                  r_angle_valid;
  logic                  r_done;

  logic [ANGLE_W-1:0]    w_idx;
  logic                  w_any;
  logic [NUM_ANGLES-1:0] w_pending_clr;

  lsb_priority_encoder #(
    .WIDTH (NUM_ANGLES),
    .IDX_W (ANGLE_W)
  ) u_lsb_enc (
    .i_req (r_pending),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_pending_clr = r_pending & ~(NUM_ANGLES'(1) << w_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pending     <= '0;
      r_busy        <= 1'b0;
      r_angle_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pending <= angles_hit;
            r_busy    <= 1'b1;
            if (|angles_hit) begin
              r_state       <= SCAN;
              r_angle_valid <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (angle_ready) begin
            r_pending <= w_pending_clr;
            if (w_pending_clr == '0) begin
              r_state       <= DONE;
              r_angle_valid <= 1'b0;
              r_done        <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state       <= IDLE;
          r_pending     <= '0;
          r_busy        <= 1'b0;
          r_angle_valid <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign angle_valid = r_angle_valid;
  assign done        = r_done;
  // Forced to zero outside SCAN so downstream never sees a stale index.
  assign angle_out   = (r_angle_valid && w_any) ? w_idx : '0;

`ifdef ANGLES_HIT_COUNT_EN
  logic [ANGLE_W:0] r_hit_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count <= '0;
    end else if (r_state == IDLE && start) begin
      r_hit_count <= popcount(angles_hit);
    end
  end

  assign hit_count = r_hit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_angles_hit_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_angles_hit_scanner                                        |
// | Description : Scoreboard bench for angles_hit_scanner                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_angles_hit_scanner;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] angles_hit;
  logic        busy;
  logic        angle_valid;
  logic        angle_ready;
  logic [3:0]  angle_out;
  logic        done;
`ifdef ANGLES_HIT_COUNT_EN
  logic [4:0]  hit_count;
`endif

  int vectors;
  int miscompares;
  logic [3:0] exp_q[$];

  angles_hit_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .angles_hit  (angles_hit),
    .busy        (busy),
    .angle_valid (angle_valid),
    .angle_ready (angle_ready),
    .angle_out   (angle_out),
    .done        (done)
`ifdef ANGLES_HIT_COUNT_EN
    ,
    .hit_count   (hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_mask(input logic [15:0] m);
    for (int i = 0; i < 16; i++) begin
      if (m[i]) exp_q.push_back(4'(i));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; angles_hit = '0; angle_ready = 1'b1;
    #1;
    vectors++;
    if ({busy, angle_valid, angle_out, done} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b valid=%b out=%0d done=%b, want all 0",
               busy, angle_valid, angle_out, done);
    end
`ifdef ANGLES_HIT_COUNT_EN
    vectors++;
    if (hit_count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_hit_count: got %0d want 0", hit_count);
    end
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Start a scan with ready high and drain it against the scoreboard.
  task automatic test_stream(input string name, input logic [15:0] mask, input int exp_hits);
    int done_cyc;
    logic [3:0] e;
    exp_q.delete();
    push_mask(mask);
    @(negedge clk); angles_hit = mask; start = 1'b1; angle_ready = 1'b1;
    @(negedge clk); start = 1'b0; angles_hit = ~mask;
    done_cyc = -1;
    for (int c = 0; c < 24 && done_cyc < 0; c++) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_busy: cycle %0d got %b want 1", name, c, busy);
      end
      if (angle_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s_extra: cycle %0d got index %0d, want no valid", name, c, angle_out);
        end else begin
          e = exp_q.pop_front();
          if (angle_out !== e) begin
            miscompares++;
            $display("FAIL %s_index: cycle %0d got %0d want %0d", name, c, angle_out, e);
          end
        end
      end
      if (done) done_cyc = c;
      else @(negedge clk);
    end
    vectors++;
    if (done_cyc !== exp_hits) begin
      miscompares++;
      $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, exp_hits);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_leftover: got %0d unissued want 0", name, exp_q.size());
    end
`ifdef ANGLES_HIT_COUNT_EN
    vectors++;
    if (hit_count !== 5'(exp_hits)) begin
      miscompares++;
      $display("FAIL %s_hit_count: got %0d want %0d", name, hit_count, exp_hits);
    end
`endif
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got busy=%b done=%b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_zero_mask();
    @(negedge clk); angles_hit = 16'h0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++;
    if ({busy, angle_valid, done} !== 3'b101) begin
      miscompares++;
      $display("FAIL zero_first: got busy=%b valid=%b done=%b want 1 0 1", busy, angle_valid, done);
    end
`ifdef ANGLES_HIT_COUNT_EN
    vectors++;
    if (hit_count !== 5'd0) begin
      miscompares++;
      $display("FAIL zero_hit_count: got %0d want 0", hit_count);
    end
`endif
    @(negedge clk);
    vectors++;
    if ({busy, angle_valid, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL zero_second: got busy=%b valid=%b done=%b want 0 0 0", busy, angle_valid, done);
    end
  endtask

  task automatic test_stall();
    logic [3:0] e;
    exp_q.delete();
    push_mask(16'h0120);
    @(negedge clk); angles_hit = 16'h0120; start = 1'b1; angle_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (angle_valid !== 1'b1 || angle_out !== exp_q[0]) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d got valid=%b out=%0d want 1 %0d",
                 c, angle_valid, angle_out, exp_q[0]);
      end
      @(negedge clk);
    end
    angle_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      e = exp_q.pop_front();
      vectors++;
      if (angle_valid !== 1'b1 || angle_out !== e) begin
        miscompares++;
        $display("FAIL stall_release: step %0d got valid=%b out=%0d want 1 %0d",
                 c, angle_valid, angle_out, e);
      end
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || angle_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: got done=%b valid=%b want 1 0", done, angle_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    logic [3:0] e;
    int done_cyc;
    exp_q.delete();
    push_mask(16'h0303);
    @(negedge clk); angles_hit = 16'h0303; start = 1'b1; angle_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < 20 && done_cyc < 0; c++) begin
      start      = (c == 1);
      angles_hit = (c == 1) ? 16'hFFFF : 16'h00F0;
      if (angle_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL ignore_extra: cycle %0d got index %0d want no valid", c, angle_out);
        end else begin
          e = exp_q.pop_front();
          if (angle_out !== e) begin
            miscompares++;
            $display("FAIL ignore_index: cycle %0d got %0d want %0d", c, angle_out, e);
          end
        end
      end
      if (done) done_cyc = c;
      else @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (done_cyc !== 4 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ignore_done: got done cycle %0d leftover %0d want 4 0", done_cyc, exp_q.size());
    end
`ifdef ANGLES_HIT_COUNT_EN
    vectors++;
    if (hit_count !== 5'd4) begin
      miscompares++;
      $display("FAIL ignore_hit_count: got %0d want 4", hit_count);
    end
`endif
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); angles_hit = 16'h0001; start = 1'b1; angle_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (angle_valid !== 1'b1 || angle_out !== 4'd0) begin
      miscompares++;
      $display("FAIL b2b_first: got valid=%b out=%0d want 1 0", angle_valid, angle_out);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: got %b want 1", done);
    end
    @(negedge clk); angles_hit = 16'h8000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (angle_valid !== 1'b1 || angle_out !== 4'd15) begin
      miscompares++;
      $display("FAIL b2b_second: got valid=%b out=%0d want 1 15", angle_valid, angle_out);
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] e;
    exp_q.delete();
    push_mask(16'hFFFF);
    @(negedge clk); angles_hit = 16'hFFFF; start = 1'b1; angle_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e = exp_q.pop_front();
      vectors++;
      if (angle_valid !== 1'b1 || angle_out !== e) begin
        miscompares++;
        $display("FAIL rstmid_index: step %0d got valid=%b out=%0d want 1 %0d",
                 c, angle_valid, angle_out, e);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, angle_valid, angle_out, done} !== 7'd0) begin
      miscompares++;
      $display("FAIL rstmid_immediate: got busy=%b valid=%b out=%0d done=%b want all 0",
               busy, angle_valid, angle_out, done);
    end
`ifdef ANGLES_HIT_COUNT_EN
    vectors++;
    if (hit_count !== 5'd0) begin
      miscompares++;
      $display("FAIL rstmid_hit_count: got %0d want 0", hit_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, angle_valid, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL rstmid_after: cycle %0d got busy=%b valid=%b done=%b want 0 0 0",
                 c, busy, angle_valid, done);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_stream("basic", 16'h000E, 3);
    test_stream("wrap", 16'hC007, 5);
    test_zero_mask();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
